mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences and shares the single main-memory RAM port between the instruction-fetch refill path (I-side) and the data-cache path (D-side: line refills and write-through stores).
- Models fixed memory latency with a countdown, then streams line beats or performs one store beat.
- Returns a one-cycle ack per transaction; the caches stall while their request is pending.

Parameters:
MEM_LAT, 9, wait cycles between grant and first memory beat; legal range 1..15
WORDS, 4, 32-bit beats per line refill; power of two, 2..8
ADDR_W, 32, byte-address width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
i_req  in  1  I-side line-refill request; held until i_ack
i_addr  in  ADDR_W  I-side byte address; stable while i_req is high
i_ack  out  1  one-cycle pulse on the final I-side beat
i_rvalid  out  1  I-side refill beat valid
i_beat  out  log2(WORDS)  index of the current I-side beat
d_req  in  1  D-side request; held until d_ack
d_we  in  1  1 = single-word store, 0 = line refill; stable while d_req is high
d_addr  in  ADDR_W  D-side byte address
d_wdata  in  32  store data
d_ack  out  1  one-cycle pulse on the final D-side beat or the store beat
d_rvalid  out  1  D-side refill beat valid
d_beat  out  log2(WORDS)  index of the current D-side beat
rdata  out  32  beat data, taken combinationally from mem_rdata; shared by both sides
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  word-aligned memory address
mem_wdata  out  32  memory write data
mem_rdata  in  32  combinational read data for mem_addr
busy  out  1  high in any state other than IDLE
owner_d  out  1  1 = current transaction belongs to D-side

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE; counter=0; last_owner=I. All outputs are 0. A transaction in flight is aborted with no ack.
- States: IDLE, WAIT, XFER.
- IDLE to WAIT: at an edge where at least one request is high.
  - Owner, address, d_we and d_wdata are latched at this edge.
  - Counter is loaded with MEM_LAT-1.
- Tie (both requests high): grant the side that is not last_owner. After reset the first tie therefore goes to D.
- WAIT: decrement the counter each cycle. Go to XFER at the edge where the counter is 0, so WAIT lasts exactly MEM_LAT cycles.
- XFER, refill:
  - Runs WORDS cycles, with beat k = 0..WORDS-1.
  - mem_en=1, mem_we=0.
  - mem_addr = {latched_addr[ADDR_W-1:log2(WORDS)+2], k, 2'b00}.
  - The owner's rvalid=1 and beat=k.
  - The owner's ack=1 in the k=WORDS-1 cycle only.
- XFER, store:
  - Runs 1 cycle with mem_en=1, mem_we=1.
  - mem_addr = latched_addr with bits [1:0] cleared; mem_wdata = latched data.
  - d_ack=1; d_rvalid=0.
- XFER to IDLE: after the last XFER cycle; last_owner takes the finished owner at the same edge.
- Latency (grant edge = edge E):
  - Read beats in cycles E+MEM_LAT+1 .. E+MEM_LAT+WORDS, so with defaults the ack comes in the 13th cycle after E.
  - Store ack in cycle E+MEM_LAT+1.
- Handshakes:
  - A requester drops req at the edge that ends its ack cycle.
  - In IDLE one cycle later, the arbiter re-samples requests. A still-pending other side wins with no extra bubble.
  - Request or address changes after grant are ignored; the latched values are used.
  - Dropping req before ack is illegal; the transaction still completes and acks.
- Starvation: under round-robin, the loser of a tie is granted next whenever it is still requesting.
- The non-owner side's ack, rvalid and beat stay 0 throughout.

Optional Feature:
- Macro: MEM_ARB_DPRI_EN.
- Defined: fixed priority. D-side always wins a tie; last_owner is still tracked, but ties ignore it. I-side can starve under continuous D-side requests.
- Undefined: round-robin as specified above.

Test Plan:
- Single D refill: d_req=1, d_we=0, d_addr=0x0000_0044 at edge E.
  - Required: mem_addr 0x40, 0x44, 0x48, 0x4C in cycles E+10..E+13.
  - d_beat 0..3; d_ack only in cycle E+13.
  - busy low in cycle E+14.
- D store: d_we=1, d_addr=0x0000_0103, d_wdata=0xDEADBEEF.
  - Required: one cycle with mem_en=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, d_ack=1, all at E+10.
  - No rvalid on either side.
- Tie after reset: i_req and d_req both rise together.
  - Required: D is granted first (owner_d=1).
  - I is granted in the IDLE cycle directly after d_ack, and its refill completes.
  - A second simultaneous tie then goes to D (round-robin).
- Reset mid-WAIT: assert reset=0 during cycle E+5 of an I refill.
  - Required: next cycle all outputs are 0 and state is IDLE; i_ack never pulses.
  - A new tie is granted to D.
- Address change after grant: change i_addr from 0x200 to 0x300 at E+3.
  - Required: beats read 0x200..0x20C.
- MEM_ARB_DPRI_EN defined: hold d_req high for three back-to-back refills with i_req high.
  - Required: three d_acks before the first I grant.
  - Undefined: grants alternate D, I, D.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I-side/D-side cache and main-memory port bundle for mem_arbiter
//
// Parameters: ADDR_W byte-address width, WORDS beats per line refill.
// I-side : i_req, i_addr -> i_ack, i_rvalid, i_beat
// D-side : d_req, d_we, d_addr, d_wdata -> d_ack, d_rvalid, d_beat
// Shared : rdata (beat data), busy, owner_d
// Memory : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
// Modports: slave = arbiter view, master = caches/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int WORDS  = 4
);
  localparam int BW = $clog2(WORDS);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic              i_rvalid;
  logic [BW-1:0]     i_beat;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic              d_rvalid;
  logic [BW-1:0]     d_beat;

  logic [31:0]       rdata;
  logic              busy;
  logic              owner_d;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rvalid, i_beat, d_ack, d_rvalid, d_beat, rdata,
           busy, owner_d, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rvalid, i_beat, d_ack, d_rvalid, d_beat, rdata,
           busy, owner_d, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one main-memory port between I-fetch refills and D-cache refills/stores
//
// Ports: clk (rising edge), reset (synchronous, active low), bus (mem_arbiter_if.slave).
// Parameters: MEM_LAT wait cycles before first beat (1..15), WORDS beats per refill
// (power of two, 2..8), ADDR_W byte-address width.
// Optional macro MEM_ARB_DPRI_EN: D-side always wins a tie (fixed priority);
// when undefined, ties alternate against the last finished owner (round-robin).
module mem_arbiter #(
  parameter int MEM_LAT = 9,
  parameter int WORDS   = 4,
  parameter int ADDR_W  = 32
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int BW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;          // latency countdown in WAIT, beat index in XFER
  logic              own_d, own_d_n;
  logic              last_d, last_d_n;    // owner of the most recently finished transaction
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;

  logic              tie_d;
  logic              grant_d;
  logic              xfer_last;
  logic [BW-1:0]     beat;

`ifdef MEM_ARB_DPRI_EN
  assign tie_d = 1'b1;
`else
  assign tie_d = ~last_d;
`endif

  assign grant_d   = bus.d_req & (~bus.i_req | tie_d);
  assign beat      = cnt[BW-1:0];
  assign xfer_last = we_q | (beat == BW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      own_d   <= 1'b0;
      last_d  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      own_d   <= own_d_n;
      last_d  <= last_d_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    own_d_n       = own_d;
    last_d_n      = last_d;
    we_n          = we_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;

    bus.i_ack     = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_beat    = '0;
    bus.d_ack     = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_beat    = '0;
    bus.rdata     = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = (state != IDLE);
    bus.owner_d   = (state != IDLE) & own_d;

    unique case (state)
      IDLE: begin
        if (bus.i_req | bus.d_req) begin
          state_n = WAIT;
          cnt_n   = 4'(MEM_LAT - 1);
          own_d_n = grant_d;
          addr_n  = grant_d ? bus.d_addr : bus.i_addr;
          // only a D-side grant can be a store
          we_n    = grant_d & bus.d_we;
          wdata_n = bus.d_wdata;
        end
      end

      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = XFER;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end

      XFER: begin
        bus.mem_en = 1'b1;
        bus.mem_we = we_q;
        if (we_q) begin
          bus.mem_addr  = addr_q & ~ADDR_W'(3);
          bus.mem_wdata = wdata_q;
          bus.d_ack     = 1'b1;
        end else begin
          // line base with the beat index substituted into the word-offset bits
          bus.mem_addr = (addr_q & ~ADDR_W'(WORDS * 4 - 1)) | (ADDR_W'(beat) << 2);
          bus.rdata    = bus.mem_rdata;
          if (own_d) begin
            bus.d_rvalid = 1'b1;
            bus.d_beat   = beat;
            bus.d_ack    = xfer_last;
          end else begin
            bus.i_rvalid = 1'b1;
            bus.i_beat   = beat;
            bus.i_ack    = xfer_last;
          end
        end
        if (xfer_last) begin
          state_n  = IDLE;
          cnt_n    = 4'd0;
          last_d_n = own_d;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end
endmodule
